ccd_timing_gen: RTL and testbench
=================================

# ccd_timing_gen

Parametrised CCD/ADC test-stimulus timing generator, the next generation of the functional-test sequencer in the BOS test FPGA. It runs in the `dds_clk` domain as its single clock and drives the DAC and the SBIS BOS analog-timing pins. Per pixel it produces CLK, SHP, SHD and DAC data. Edge positions are programmable rather than fixed fractions, and the block adds line/frame structure (HD, VD, clamp, blanking). Samples come from an external show-ahead FIFO through a read-request/empty handshake.

## Interface
- `DAC_W`, 14, DAC data width.
- `PER_W`, 9, width of pixel-period and phase-edge fields (dds_clk cycles).
- `PIX_W`, 10, width of pixels-per-line and blank-length fields.
- `LIN_W`, 10, width of lines-per-frame field.
- `dds_clk` in 1: single clock.
- `n_rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle start strobe; honoured only in IDLE.
- `stop` in 1: one-cycle stop strobe; honoured only in RUN.
- `cfg_ccd` in 1: 1 = CCD mode, 0 = plain-ADC mode.
- `cfg_periodic` in 1: 1 = replay head sample without popping; 0 = one-shot, pop per active pixel.
- `cfg_period` in PER_W: pixel period in cycles, minimum 4.
- `cfg_clk_fall`, `cfg_shp_fall`, `cfg_shp_rise`, `cfg_shd_fall`, `cfg_shd_rise` in PER_W each: phase edge positions within the period.
- `cfg_line_len` in PIX_W: pixels per line, including blanking.
- `cfg_blank` in PIX_W: blank pixels at the end of each line.
- `cfg_frame_len` in LIN_W: lines per frame.
- `cfg_black` in DAC_W: black level.
- `sample_q` in DAC_W: FIFO head data (show-ahead).
- `sample_empty` in 1: FIFO empty.
- `sample_rdreq` out 1: FIFO pop, one-cycle pulse.
- `dac_d` out DAC_W: DAC data.
- `clk_o`, `shp_o`, `shd_o`, `clpdm_o`, `clpob_o`, `hd_o`, `vd_o` out 1 each: BOS timing pins.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on one-shot completion.

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE:
  - `start` latches all `cfg_*` into shadow registers.
  - Counters are cleared and the block enters RUN.
  - `cfg_*` changes during RUN have no effect.
- Counters:
  - `ph` runs 0..period-1.
  - `pix` increments when `ph` wraps, running 0..line_len-1.
  - `lin` increments when `pix` wraps, running 0..frame_len-1.
  - `pix` and `lin` wrap to 0.
- Active pixel: `pix < line_len - blank`. Otherwise the pixel is a blank pixel.
- Phase waveforms (registered):
  - `clk_o` is set at `ph`==0 and cleared at `clk_fall`.
  - `shp_o` is cleared at `shp_fall` and set at `shp_rise`.
  - `shd_o` is cleared at `shd_fall` and set at `shd_rise`.
  - If a set and a clear fall on the same `ph`, the clear wins.
- DAC data:
  - CCD mode, active pixel: `dac_d` takes `sample_q` at `ph`==0.
  - Plain-ADC mode, active pixel: `dac_d` takes `cfg_black` at `ph`==0 and `sample_q` at `ph`==period>>1.
  - Blank pixel (both modes): `dac_d` = `cfg_black`.
- Line/frame signals:
  - `clpdm_o` is 1 on active pixels and 0 on blank pixels; it updates at `ph`==0.
  - `clpob_o` = `clpdm_o`.
  - `hd_o` is 1 during blank pixels.
  - `vd_o` is 1 during the whole last line of a frame.
- FIFO pop:
  - `sample_rdreq` pulses at `ph`==period-1 of an active pixel.
  - Conditions: one-shot mode and `!sample_empty`.
  - Periodic mode never pops.
- One-shot end:
  - If `sample_empty` is seen at a pixel boundary (`ph` wrap) before an active pixel, the block enters DRAIN.
  - DRAIN runs exactly one more period with blank-pixel outputs.
  - The block then goes to IDLE and pulses `done`.
- `stop` in RUN:
  - The current period completes, then the block goes to IDLE.
  - No `done` pulse.
  - In DRAIN, `stop` is ignored.
- Config clamps:
  - `cfg_period` < 4 is treated as 4.
  - `cfg_blank` ≥ `cfg_line_len`: all pixels are blank.
  - `cfg_line_len`=0 or `cfg_frame_len`=0 is treated as 1.
  - Edge values ≥ period never fire.
- Idle/reset output levels:
  - `clk_o`, `shp_o`, `shd_o` = 1.
  - `clpdm_o`, `clpob_o`, `hd_o`, `vd_o`, `sample_rdreq`, `busy`, `done` = 0.
  - `dac_d` = 0.
- Reset mid-operation: everything returns to IDLE values on the next edge. No pop is issued.

## Timing
- Start strobe at cycle N: state = RUN and `ph`=0 at N+1. Outputs for `ph`=0 appear at N+2. All outputs are registered, with 1-cycle latency from the counters.
- FIFO read: `sample_q` is sampled at `ph`==0 of the pixel following the pop. The FIFO must present new data within period-1 cycles; a show-ahead FIFO with 1-cycle read latency satisfies this.
- `start` and `stop` in the same cycle:
  - In IDLE, start wins.
  - In RUN, stop wins.

## Structure
- Shared package `ccd_timing_pkg`:
  - state enum (IDLE/RUN/DRAIN)
  - `MIN_PERIOD`=4
  - idle-level constants
- One sub-module, `ccd_phase_edges`:
  - Takes `ph` and the five edge values.
  - Produces registered `clk_o`/`shp_o`/`shd_o` with clear-wins priority.
- Counters, FSM, data path and FIFO handshake stay in the top level.

## Test plan
- CCD one-shot, period 8:
  - Settings: `clk_fall` 4, `shp` 1/3, `shd` 5/7, `line_len` 6, `blank` 2, `frame_len` 2, FIFO preloaded with 0x100..0x107.
  - Expected: 8 pops; `dac_d` follows 0x100.. on active pixels and `cfg_black` on blank pixels; `hd_o` high on pixels 4-5; `vd_o` high on line 1.
  - On empty: one DRAIN period, then `done` pulses once and `busy` falls.
- Plain-ADC mode, period 10, black 0x0AA, sample 0x3FF:
  - Expected: `dac_d` = 0x0AA from `ph`0 and 0x3FF from `ph`5 of each active pixel.
- Periodic mode with FIFO holding 0x123, 50 pixels:
  - Expected: no `sample_rdreq`; `dac_d` stays 0x123 on active pixels.
  - `stop` at `ph`3: IDLE levels appear after the period ends; `done` stays 0.
- Clamp checks:
  - `cfg_period`=2 behaves as 4.
  - `shp_fall`=`shp_rise`=2: `shp_o` is cleared.
  - `blank`=`line_len`: `clpdm_o` stays 0 throughout.
- Strobe/reset interactions:
  - `start` during RUN is ignored.
  - `n_rst` low mid-line: all outputs at reset values next cycle; `sample_rdreq` stays 0.
  - `start` and `stop` together in IDLE: the block starts.

Source files
------------

// File: rtl/ccd_timing_pkg.sv
// rtl/ccd_timing_pkg.sv - shared types and constants for the CCD timing generator
package ccd_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int   MIN_PERIOD     = 4;
    localparam logic PHASE_IDLE_LVL = 1'b1;
    localparam logic LINE_IDLE_LVL  = 1'b0;

endpackage

// File: rtl/ccd_phase_edges.sv
// rtl/ccd_phase_edges.sv - registered CLK/SHP/SHD phase waveforms from the phase counter
module ccd_phase_edges
    import ccd_timing_pkg::*;
#(
    parameter int PER_W = 9
) (
    input  logic             dds_clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [PER_W-1:0] ph,
    input  logic [PER_W-1:0] clk_fall,
    input  logic [PER_W-1:0] shp_fall,
    input  logic [PER_W-1:0] shp_rise,
    input  logic [PER_W-1:0] shd_fall,
    input  logic [PER_W-1:0] shd_rise,
    output logic             clk_o,
    output logic             shp_o,
    output logic             shd_o
);

    // Clear is tested first so a coincident set/clear leaves the pin low.
    always_ff @(posedge dds_clk) begin
        if (!n_rst || !en) begin
            clk_o <= PHASE_IDLE_LVL;
            shp_o <= PHASE_IDLE_LVL;
            shd_o <= PHASE_IDLE_LVL;
        end else begin
            if (ph == clk_fall)      clk_o <= 1'b0;
            else if (ph == '0)       clk_o <= 1'b1;

            if (ph == shp_fall)      shp_o <= 1'b0;
            else if (ph == shp_rise) shp_o <= 1'b1;

            if (ph == shd_fall)      shd_o <= 1'b0;
            else if (ph == shd_rise) shd_o <= 1'b1;
        end
    end

endmodule

// File: rtl/ccd_timing_gen.sv
// rtl/ccd_timing_gen.sv - CCD/ADC stimulus timing generator: counters, FSM, DAC data and FIFO handshake
module ccd_timing_gen
    import ccd_timing_pkg::*;
#(
    parameter int DAC_W = 14,
    parameter int PER_W = 9,
    parameter int PIX_W = 10,
    parameter int LIN_W = 10
) (
    input  logic             dds_clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_ccd,
    input  logic             cfg_periodic,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PER_W-1:0] cfg_clk_fall,
    input  logic [PER_W-1:0] cfg_shp_fall,
    input  logic [PER_W-1:0] cfg_shp_rise,
    input  logic [PER_W-1:0] cfg_shd_fall,
    input  logic [PER_W-1:0] cfg_shd_rise,
    input  logic [PIX_W-1:0] cfg_line_len,
    input  logic [PIX_W-1:0] cfg_blank,
    input  logic [LIN_W-1:0] cfg_frame_len,
    input  logic [DAC_W-1:0] cfg_black,
    input  logic [DAC_W-1:0] sample_q,
    input  logic             sample_empty,
    output logic             sample_rdreq,
    output logic [DAC_W-1:0] dac_d,
    output logic             clk_o,
    output logic             shp_o,
    output logic             shd_o,
    output logic             clpdm_o,
    output logic             clpob_o,
    output logic             hd_o,
    output logic             vd_o,
    output logic             busy,
    output logic             done
);

    state_t state_q, state_d;

    logic [PER_W-1:0] per_s, clk_fall_s, shp_fall_s, shp_rise_s, shd_fall_s, shd_rise_s;
    logic [PIX_W-1:0] line_s, act_s;
    logic [LIN_W-1:0] frame_s;
    logic [DAC_W-1:0] black_s;
    logic             ccd_s, periodic_s;

    logic [PER_W-1:0] ph;
    logic [PIX_W-1:0] pix, pix_nx;
    logic [LIN_W-1:0] lin;
    logic             stop_req;

    logic [PER_W-1:0] per_c;
    logic [PIX_W-1:0] line_c, act_c;
    logic [LIN_W-1:0] frame_c;
    logic             wrap, pix_last, lin_last, active, stop_now;

    // Configuration clamps applied once, when the shadow copy is taken.
    assign per_c   = (cfg_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cfg_period;
    assign line_c  = (cfg_line_len == '0) ? PIX_W'(1) : cfg_line_len;
    assign frame_c = (cfg_frame_len == '0) ? LIN_W'(1) : cfg_frame_len;
    assign act_c   = (cfg_blank >= line_c) ? '0 : line_c - cfg_blank;

    assign wrap     = (ph == per_s - PER_W'(1));
    assign pix_last = (pix == line_s - PIX_W'(1));
    assign lin_last = (lin == frame_s - LIN_W'(1));
    assign pix_nx   = pix_last ? '0 : pix + PIX_W'(1);
    assign active   = (state_q == ST_RUN) && (pix < act_s);
    assign stop_now = stop_req | stop;

    always_ff @(posedge dds_clk) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (wrap) begin
                    if (stop_now)
                        state_d = ST_IDLE;
                    else if (!periodic_s && (pix_nx < act_s) && sample_empty)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (wrap) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dds_clk) begin
        if (!n_rst) begin
            ph <= '0; pix <= '0; lin <= '0; stop_req <= 1'b0;
            per_s <= '0; clk_fall_s <= '0; shp_fall_s <= '0; shp_rise_s <= '0;
            shd_fall_s <= '0; shd_rise_s <= '0; line_s <= '0; act_s <= '0;
            frame_s <= '0; black_s <= '0; ccd_s <= 1'b0; periodic_s <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            ph <= '0; pix <= '0; lin <= '0; stop_req <= 1'b0;
            if (start) begin
                per_s      <= per_c;
                clk_fall_s <= cfg_clk_fall;
                shp_fall_s <= cfg_shp_fall;
                shp_rise_s <= cfg_shp_rise;
                shd_fall_s <= cfg_shd_fall;
                shd_rise_s <= cfg_shd_rise;
                line_s     <= line_c;
                act_s      <= act_c;
                frame_s    <= frame_c;
                black_s    <= cfg_black;
                ccd_s      <= cfg_ccd;
                periodic_s <= cfg_periodic;
            end
        end else begin
            ph <= wrap ? '0 : ph + PER_W'(1);
            if (state_q == ST_RUN) begin
                stop_req <= stop_now;
                if (wrap) begin
                    pix <= pix_nx;
                    if (pix_last) lin <= lin_last ? '0 : lin + LIN_W'(1);
                end
            end
        end
    end

    // Output stage: everything lags the counters by exactly one cycle.
    always_ff @(posedge dds_clk) begin
        if (!n_rst || state_q == ST_IDLE) begin
            dac_d        <= '0;
            clpdm_o      <= LINE_IDLE_LVL;
            hd_o         <= LINE_IDLE_LVL;
            vd_o         <= LINE_IDLE_LVL;
            sample_rdreq <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy         <= 1'b1;
            hd_o         <= !active;
            vd_o         <= lin_last;
            sample_rdreq <= active && !periodic_s && !sample_empty && wrap;
            done         <= (state_q == ST_DRAIN) && wrap;
            if (ph == '0) clpdm_o <= active;
            if (!active)
                dac_d <= black_s;
            else if (ph == '0)
                dac_d <= ccd_s ? sample_q : black_s;
            else if (!ccd_s && ph == (per_s >> 1))
                dac_d <= sample_q;
        end
    end

    assign clpob_o = clpdm_o;

    ccd_phase_edges #(.PER_W(PER_W)) u_phase_edges (
        .dds_clk  (dds_clk),
        .n_rst    (n_rst),
        .en       (state_q != ST_IDLE),
        .ph       (ph),
        .clk_fall (clk_fall_s),
        .shp_fall (shp_fall_s),
        .shp_rise (shp_rise_s),
        .shd_fall (shd_fall_s),
        .shd_rise (shd_rise_s),
        .clk_o    (clk_o),
        .shp_o    (shp_o),
        .shd_o    (shd_o)
    );

endmodule

// File: tb/tb_ccd_timing_gen.sv
// tb/tb_ccd_timing_gen.sv - directed self-checking bench for ccd_timing_gen
module tb_ccd_timing_gen;

    localparam int DAC_W = 14;
    localparam int PER_W = 9;
    localparam int PIX_W = 10;
    localparam int LIN_W = 10;

    logic             dds_clk = 1'b0;
    logic             n_rst, start, stop, cfg_ccd, cfg_periodic;
    logic [PER_W-1:0] cfg_period, cfg_clk_fall, cfg_shp_fall, cfg_shp_rise, cfg_shd_fall, cfg_shd_rise;
    logic [PIX_W-1:0] cfg_line_len, cfg_blank;
    logic [LIN_W-1:0] cfg_frame_len;
    logic [DAC_W-1:0] cfg_black, sample_q;
    logic             sample_empty = 1'b1;
    logic             sample_rdreq, clk_o, shp_o, shd_o, clpdm_o, clpob_o, hd_o, vd_o, busy, done;
    logic [DAC_W-1:0] dac_d;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [DAC_W-1:0] fifo[$];

    ccd_timing_gen #(.DAC_W(DAC_W), .PER_W(PER_W), .PIX_W(PIX_W), .LIN_W(LIN_W)) dut (
        .dds_clk(dds_clk), .n_rst(n_rst), .start(start), .stop(stop),
        .cfg_ccd(cfg_ccd), .cfg_periodic(cfg_periodic), .cfg_period(cfg_period),
        .cfg_clk_fall(cfg_clk_fall), .cfg_shp_fall(cfg_shp_fall), .cfg_shp_rise(cfg_shp_rise),
        .cfg_shd_fall(cfg_shd_fall), .cfg_shd_rise(cfg_shd_rise), .cfg_line_len(cfg_line_len),
        .cfg_blank(cfg_blank), .cfg_frame_len(cfg_frame_len), .cfg_black(cfg_black),
        .sample_q(sample_q), .sample_empty(sample_empty), .sample_rdreq(sample_rdreq),
        .dac_d(dac_d), .clk_o(clk_o), .shp_o(shp_o), .shd_o(shd_o), .clpdm_o(clpdm_o),
        .clpob_o(clpob_o), .hd_o(hd_o), .vd_o(vd_o), .busy(busy), .done(done)
    );

    always #5 dds_clk = ~dds_clk;

    // Show-ahead FIFO model: a pop takes effect mid-cycle, head is presented before the next edge.
    always @(negedge dds_clk) begin
        if (sample_rdreq) begin
            rd_cnt++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (done) done_cnt++;
        sample_empty = (fifo.size() == 0);
        sample_q     = (fifo.size() > 0) ? fifo[0] : '0;
    end

    task automatic tick();
        @(posedge dds_clk);
        #1;
    endtask

    task automatic set_cfg(input bit ccd, input bit periodic, input int period, input int cf,
                           input int spf, input int spr, input int sdf, input int sdr,
                           input int line, input int blank, input int frame, input logic [DAC_W-1:0] black);
        cfg_ccd = ccd; cfg_periodic = periodic; cfg_period = PER_W'(period);
        cfg_clk_fall = PER_W'(cf); cfg_shp_fall = PER_W'(spf); cfg_shp_rise = PER_W'(spr);
        cfg_shd_fall = PER_W'(sdf); cfg_shd_rise = PER_W'(sdr);
        cfg_line_len = PIX_W'(line); cfg_blank = PIX_W'(blank); cfg_frame_len = LIN_W'(frame);
        cfg_black = black;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; stop = 1'b0;
        set_cfg(1, 0, 8, 4, 1, 3, 5, 7, 6, 2, 2, 14'h055);
        tick(); tick();
        checks++;
        if ({clk_o, shp_o, shd_o, clpdm_o, clpob_o, hd_o, vd_o, sample_rdreq, busy, done} !== 10'b1110000000) begin
            errors++;
            $display("FAIL reset_levels got=%b required 1110000000",
                     {clk_o, shp_o, shd_o, clpdm_o, clpob_o, hd_o, vd_o, sample_rdreq, busy, done});
        end
        checks++;
        if (dac_d !== '0) begin errors++; $display("FAIL reset_dac got=%h required 0", dac_d); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_ccd_oneshot();
        int ph, p, pix, lin, r0, d0;
        bit act;
        logic [8:0] exp_v;
        logic [DAC_W-1:0] exp_dac;
        set_cfg(1, 0, 8, 4, 1, 3, 5, 7, 6, 2, 2, 14'h055);
        fifo.delete();
        for (int i = 0; i < 8; i++) fifo.push_back(DAC_W'(32'h100 + i));
        tick();
        r0 = rd_cnt; d0 = done_cnt;
        do_start();
        for (int k = 0; k < 104; k++) begin
            tick();
            ph = k % 8; p = k / 8; pix = p % 6; lin = (p / 6) % 2;
            act = (p < 12) && (pix < 4);
            exp_v = {ph < 4, !(ph == 1 || ph == 2), !(ph == 5 || ph == 6), !act, lin == 1,
                     act, act && ph == 7, k == 103, 1'b1};
            exp_dac = act ? DAC_W'(32'h100 + lin * 4 + pix) : 14'h055;
            checks++;
            if ({clk_o, shp_o, shd_o, hd_o, vd_o, clpdm_o, sample_rdreq, done, busy} !== exp_v) begin
                errors++;
                $display("FAIL ccd_pins k=%0d got=%b required %b", k,
                         {clk_o, shp_o, shd_o, hd_o, vd_o, clpdm_o, sample_rdreq, done, busy}, exp_v);
            end
            checks++;
            if (dac_d !== exp_dac) begin
                errors++;
                $display("FAIL ccd_dac k=%0d got=%h required %h", k, dac_d, exp_dac);
            end
        end
        tick();
        checks++;
        if ({busy, done, clk_o} !== 3'b001 || dac_d !== '0) begin
            errors++;
            $display("FAIL ccd_end_idle busy/done/clk=%b dac=%h required 001 dac 0", {busy, done, clk_o}, dac_d);
        end
        checks++;
        if (rd_cnt - r0 !== 8) begin errors++; $display("FAIL ccd_pop_count got=%0d required 8", rd_cnt - r0); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ccd_done_count got=%0d required 1", done_cnt - d0); end
    endtask

    task automatic test_adc();
        int ph, pix;
        bit act;
        logic [DAC_W-1:0] exp_dac;
        set_cfg(0, 1, 10, 5, 1, 3, 6, 8, 4, 1, 1, 14'h0AA);
        fifo.delete();
        fifo.push_back(14'h3FF);
        tick();
        do_start();
        for (int k = 0; k < 40; k++) begin
            tick();
            ph = k % 10; pix = k / 10; act = pix < 3;
            exp_dac = (act && ph >= 5) ? 14'h3FF : 14'h0AA;
            checks++;
            if (dac_d !== exp_dac) begin
                errors++;
                $display("FAIL adc_dac k=%0d got=%h required %h", k, dac_d, exp_dac);
            end
            checks++;
            if ({hd_o, vd_o} !== {!act, 1'b1}) begin
                errors++;
                $display("FAIL adc_hd_vd k=%0d got=%b required %b", k, {hd_o, vd_o}, {!act, 1'b1});
            end
        end
        do_stop();
    endtask

    task automatic test_periodic_stop();
        int pix, r0, d0;
        logic [DAC_W-1:0] exp_dac;
        set_cfg(1, 1, 5, 2, 1, 3, 3, 4, 5, 1, 3, 14'h011);
        fifo.delete();
        fifo.push_back(14'h123);
        tick();
        r0 = rd_cnt; d0 = done_cnt;
        do_start();
        for (int j = 1; j <= 253; j++) begin
            tick();
            pix = ((j - 1) / 5) % 5;
            exp_dac = (pix < 4) ? 14'h123 : 14'h011;
            checks++;
            if (dac_d !== exp_dac) begin
                errors++;
                $display("FAIL periodic_dac idx=%0d got=%h required %h", j - 1, dac_d, exp_dac);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stop_period_end busy=%b required 1", busy); end
        tick();
        checks++;
        if ({busy, clk_o, shp_o, shd_o, hd_o, vd_o, clpdm_o} !== 7'b0111000 || dac_d !== '0) begin
            errors++;
            $display("FAIL stop_idle pins=%b dac=%h required 0111000 dac 0",
                     {busy, clk_o, shp_o, shd_o, hd_o, vd_o, clpdm_o}, dac_d);
        end
        checks++;
        if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL periodic_pops got=%0d required 0", rd_cnt - r0); end
        checks++;
        if (done_cnt - d0 !== 0) begin errors++; $display("FAIL stop_done got=%0d required 0", done_cnt - d0); end
    endtask

    task automatic test_clamps();
        logic [4:0] exp_v;
        set_cfg(1, 0, 2, 2, 2, 2, 7, 7, 3, 3, 1, 14'h022);
        fifo.delete();
        tick();
        do_start();
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_v = {(k % 4) < 2, k < 2, 1'b1, 1'b0, 1'b1};
            checks++;
            if ({clk_o, shp_o, shd_o, clpdm_o, hd_o} !== exp_v || dac_d !== 14'h022) begin
                errors++;
                $display("FAIL clamp k=%0d pins=%b dac=%h required %b dac 022", k,
                         {clk_o, shp_o, shd_o, clpdm_o, hd_o}, dac_d, exp_v);
            end
        end
        do_stop();
    endtask

    task automatic test_start_in_run();
        set_cfg(1, 1, 8, 4, 1, 3, 5, 7, 6, 2, 2, 14'h055);
        fifo.delete();
        fifo.push_back(14'h200);
        tick();
        do_start();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int idx = 6; idx < 16; idx++) begin
            tick();
            checks++;
            if ({clk_o, busy} !== {(idx % 8) < 4, 1'b1}) begin
                errors++;
                $display("FAIL start_in_run idx=%0d clk/busy=%b required %b", idx,
                         {clk_o, busy}, {(idx % 8) < 4, 1'b1});
            end
        end
        do_stop();
    endtask

    task automatic test_reset_mid();
        int r0;
        set_cfg(1, 0, 4, 2, 1, 3, 5, 7, 4, 0, 1, 14'h033);
        fifo.delete();
        for (int i = 0; i < 10; i++) fifo.push_back(DAC_W'(32'h300 + i));
        tick();
        r0 = rd_cnt;
        do_start();
        repeat (3) tick();
        n_rst = 1'b0;
        tick();
        checks++;
        if ({clk_o, shp_o, shd_o, clpdm_o, hd_o, vd_o, sample_rdreq, busy} !== 8'b11100000 || dac_d !== '0) begin
            errors++;
            $display("FAIL reset_mid pins=%b dac=%h required 11100000 dac 0",
                     {clk_o, shp_o, shd_o, clpdm_o, hd_o, vd_o, sample_rdreq, busy}, dac_d);
        end
        tick();
        n_rst = 1'b1;
        tick();
        checks++;
        if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL reset_mid_pop got=%0d required 0", rd_cnt - r0); end
        fifo.delete();
    endtask

    task automatic test_start_stop_together();
        set_cfg(1, 1, 6, 3, 1, 3, 4, 5, 4, 1, 1, 14'h044);
        fifo.delete();
        fifo.push_back(14'h050);
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_stop_idle busy=%b required 1", busy); end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_ccd_oneshot();
        test_adc();
        test_periodic_stop();
        test_clamps();
        test_start_in_run();
        test_reset_mid();
        test_start_stop_together();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
